// File: rtl/kbest_elect_ctrl_if.sv
// Parent-group input and survivor output bundle for the K-best election controller.
interface kbest_elect_ctrl_if #(
    parameter int N      = 2,
    parameter int K      = 4,
    parameter int ERR_WL = 16
);
    logic                           in_valid;
    logic                           in_ready;
    logic [K*4-1:0][N*2-1:0]        PATH_in;
    logic [K*4-1:0][ERR_WL-1:0]     PED_in;
    logic                           out_valid;
    logic                           out_ready;
    logic [K-1:0][N*2-1:0]          PATH_out;
    logic [K-1:0][ERR_WL-1:0]       PED_out;
    logic [K-1:0][1:0]              SRC_out;
    logic                           busy;

    modport master (
        output in_valid, PATH_in, PED_in, out_ready,
        input  in_ready, out_valid, PATH_out, PED_out, SRC_out, busy
    );

    modport slave (
        input  in_valid, PATH_in, PED_in, out_ready,
        output in_ready, out_valid, PATH_out, PED_out, SRC_out, busy
    );
endinterface

// File: rtl/kbest_elect_ctrl.sv
// Sequential K-best survivor election: one survivor per cycle from K=4 sorted parent groups.
// Optional ELECT_PED_NORM_EN: store survivor PEDs relative to the layer minimum.
module kbest_elect_ctrl #(
    parameter int N      = 2,
    parameter int K      = 4,
    parameter int ERR_WL = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    kbest_elect_ctrl_if.slave  bus
);
    localparam int NE = K * 4;
    localparam int PW = N * 2;

    typedef enum logic [1:0] {IDLE, ELECT, DONE} state_t;

    state_t                   state;
    logic [NE-1:0][PW-1:0]    path_r;
    logic [NE-1:0][ERR_WL-1:0] ped_r;
    logic [K-1:0][2:0]        ptr;
    logic [1:0]               cnt;
    logic [K-1:0][PW-1:0]     path_o;
    logic [K-1:0][ERR_WL-1:0] ped_o;
    logic [K-1:0][1:0]        src_o;
    logic                     out_valid_r;
    logic                     busy_r;
`ifdef ELECT_PED_NORM_EN
    logic [ERR_WL-1:0]        min_ped;
`endif

    // Head of each group: entry ptr[j], exhausted once ptr[j] reaches 4.
    logic [K-1:0]             cand_vld;
    logic [K-1:0][ERR_WL-1:0] cand_ped;
    logic [K-1:0][PW-1:0]     cand_path;

    for (genvar j = 0; j < K; j++) begin : g_head
        localparam logic [1:0] GJ = 2'(j);
        assign cand_vld[j]  = ~ptr[j][2];
        assign cand_ped[j]  = ped_r[{GJ, ptr[j][1:0]}];
        assign cand_path[j] = path_r[{GJ, ptr[j][1:0]}];
    end

    logic [1:0]        win_idx;
    logic [ERR_WL-1:0] win_ped;
    logic [PW-1:0]     win_path;
    logic              found;
    logic [ERR_WL-1:0] store_ped;

    // Strict less-than keeps the lowest group index on ties.
    always_comb begin
        win_idx  = '0;
        win_ped  = '0;
        win_path = '0;
        found    = 1'b0;
        for (int j = 0; j < K; j++) begin
            if (cand_vld[j] && (!found || cand_ped[j] < win_ped)) begin
                found    = 1'b1;
                win_idx  = 2'(j);
                win_ped  = cand_ped[j];
                win_path = cand_path[j];
            end
        end
    end

`ifdef ELECT_PED_NORM_EN
    // Survivor 0 is the global minimum, so later differences never go negative.
    assign store_ped = (cnt == 2'd0) ? '0 : win_ped - min_ped;
`else
    assign store_ped = win_ped;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            path_r      <= '0;
            ped_r       <= '0;
            ptr         <= '0;
            cnt         <= '0;
            path_o      <= '0;
            ped_o       <= '0;
            src_o       <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef ELECT_PED_NORM_EN
            min_ped     <= '0;
`endif
        end else if (flush) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            path_o      <= '0;
            ped_o       <= '0;
            src_o       <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        path_r <= bus.PATH_in;
                        ped_r  <= bus.PED_in;
                        ptr    <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= ELECT;
                    end
                end
                ELECT: begin
                    path_o[cnt] <= win_path;
                    ped_o[cnt]  <= store_ped;
                    src_o[cnt]  <= win_idx;
`ifdef ELECT_PED_NORM_EN
                    if (cnt == 2'd0) min_ped <= win_ped;
`endif
                    if (!ptr[win_idx][2]) ptr[win_idx] <= ptr[win_idx] + 3'd1;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'(K - 1)) begin
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.PATH_out  = path_o;
    assign bus.PED_out   = ped_o;
    assign bus.SRC_out   = src_o;
endmodule

// File: tb/tb_kbest_elect_ctrl.sv
// Directed bench for kbest_elect_ctrl with a scoreboard of expected survivor sets.
module tb_kbest_elect_ctrl;
    localparam int N  = 2;
    localparam int K  = 4;
    localparam int EW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    kbest_elect_ctrl_if #(.N(N), .K(K), .ERR_WL(EW)) bus ();
    kbest_elect_ctrl #(.N(N), .K(K), .ERR_WL(EW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus)
    );

    typedef struct {
        logic [63:0] ped;
        logic [7:0]  src;
        logic [15:0] path;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [15:0][15:0] peds_a, peds_b, peds_c, peds_x;
    exp_t exp_a, exp_b, exp_c;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] p4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [7:0] s4(input int a, input int b, input int c, input int d);
        return {2'(d), 2'(c), 2'(b), 2'(a)};
    endfunction

    function automatic logic [15:0] a4(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    // Returns #1 after the accept edge.
    task automatic drive(input logic [15:0][15:0] peds);
        @(negedge clk);
        for (int i = 0; i < 16; i++) bus.PATH_in[i] = 4'(i);
        bus.PED_in   = peds;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd4);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ped"},  bus.PED_out,  e.ped);
            chk({tag, "_src"},  64'(bus.SRC_out),  64'(e.src));
            chk({tag, "_path"}, 64'(bus.PATH_out), 64'(e.path));
            chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
            chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
    endtask

    task automatic release_done(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk({tag, "_rel_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_rel_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_rel_busy"},  64'(bus.busy), 64'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_busy"},  64'(bus.busy), 64'd0);
        chk({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.PATH_in   = '0;
        bus.PED_in    = '0;

        for (int j = 0; j < 4; j++)
            for (int e = 0; e < 4; e++) begin
                peds_a[j*4+e] = (e == 0) ? 16'(10 * (j + 1)) : 16'd50;
                peds_b[j*4+e] = (j == 0) ? 16'(e + 1) : 16'd100;
                peds_c[j*4+e] = (e == 0) ? 16'd7 : 16'd9;
                peds_x[j*4+e] = 16'd3;
            end
`ifdef ELECT_PED_NORM_EN
        exp_a.ped = p4(0, 10, 20, 30);
        exp_b.ped = p4(0, 1, 2, 3);
        exp_c.ped = p4(0, 0, 0, 0);
`else
        exp_a.ped = p4(10, 20, 30, 40);
        exp_b.ped = p4(1, 2, 3, 4);
        exp_c.ped = p4(7, 7, 7, 7);
`endif
        exp_a.src  = s4(0, 1, 2, 3);
        exp_a.path = a4(0, 4, 8, 12);
        exp_b.src  = s4(0, 0, 0, 0);
        exp_b.path = a4(0, 1, 2, 3);
        exp_c.src  = s4(0, 1, 2, 3);
        exp_c.path = a4(0, 4, 8, 12);

        #1;
        chk_idle("reset");
        chk("reset_ped",  bus.PED_out, 64'd0);
        chk("reset_src",  64'(bus.SRC_out), 64'd0);
        chk("reset_path", 64'(bus.PATH_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Distinct heads
        drive(peds_a); sb.push_back(exp_a);
        wait_done("heads"); check_out("heads"); release_done("heads");

        // One group supplies every survivor
        drive(peds_b); sb.push_back(exp_b);
        wait_done("grp0"); check_out("grp0"); release_done("grp0");

        // All ties
        drive(peds_c); sb.push_back(exp_c);
        wait_done("ties"); check_out("ties"); release_done("ties");

        // Stall in DONE with a stray in_valid pulse
        drive(peds_a); sb.push_back(exp_a);
        wait_done("stall");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = (i == 1);
            bus.PED_in   = peds_x;
            @(posedge clk);
            #1;
            chk("stall_ped",   bus.PED_out, exp_a.ped);
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        check_out("stall"); release_done("stall");

        // Async reset during the second ELECT cycle
        drive(peds_a);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_idle("rst_mid");
        chk("rst_mid_ped", bus.PED_out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Flush early in ELECT
        drive(peds_a);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk_idle("flush_mid");

        // Flush on the last ELECT cycle: out_valid must never rise
        drive(peds_a);
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk_idle("flush_last");
        repeat (3) @(posedge clk);
        #1 chk("flush_last_hold", 64'(bus.out_valid), 64'd0);

        // Recovery run
        drive(peds_a); sb.push_back(exp_a);
        wait_done("again"); check_out("again"); release_done("again");

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
